// File: rtl/ro_puf_challenger.sv
// rtl/ro_puf_challenger.sv - RO PUF challenge sequencer with per-challenge majority voting
// Drives challenge/ro_en windows, votes on the synchronized response and returns a word over valid/ready.
module ro_puf_challenger #(
    parameter int RESP_BITS     = 16,
    parameter int VOTES         = 3,
    parameter int WIN_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           base_chal,
    output logic                 busy,
    output logic                 ro_en,
    output logic [7:0]           challenge,
    input  logic                 response,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data
);

    localparam int CMAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int VW   = $clog2(VOTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        MEASURE,
        HOLD,
        DONE
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [IW-1:0]        r_idx, w_idx_nxt;
    logic [VW-1:0]        r_v, w_v_nxt;
    logic [VW-1:0]        r_ones, w_ones_nxt;
    logic [7:0]           r_base, w_base_nxt;
    logic [7:0]           r_chal, w_chal_nxt;
    logic                 r_ro_en, w_ro_en_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [RESP_BITS-1:0] r_data, w_data_nxt;
    logic [1:0]           r_sync;
    logic                 w_resp_s;
    logic [VW-1:0]        w_ones_total;

    assign w_resp_s     = r_sync[1];
    assign w_ones_total = r_ones + {{(VW-1){1'b0}}, w_resp_s};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_v_nxt     = r_v;
        w_ones_nxt  = r_ones;
        w_base_nxt  = r_base;
        w_chal_nxt  = r_chal;
        w_ro_en_nxt = r_ro_en;
        w_busy_nxt  = r_busy;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_base_nxt  = base_chal;
                    w_chal_nxt  = base_chal;
                    w_idx_nxt   = '0;
                    w_v_nxt     = '0;
                    w_ones_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_ro_en_nxt = 1'b1;
                    w_state_nxt = MEASURE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (r_cnt == CW'(WIN_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_ro_en_nxt = 1'b0;
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (r_v < VW'(VOTES - 1)) begin
                        w_v_nxt     = r_v + 1'b1;
                        w_ones_nxt  = w_ones_total;
                        w_state_nxt = SETUP;
                    end else begin
                        // Last vote for this challenge: commit the majority bit.
                        w_data_nxt[r_idx] = (w_ones_total > VW'(VOTES / 2));
                        w_v_nxt    = '0;
                        w_ones_nxt = '0;
                        if (r_idx == IW'(RESP_BITS - 1)) begin
                            w_valid_nxt = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_chal_nxt  = r_base + 8'(r_idx) + 8'd1;
                            w_state_nxt = SETUP;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_v     <= '0;
            r_ones  <= '0;
            r_base  <= '0;
            r_chal  <= '0;
            r_ro_en <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sync  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_v     <= w_v_nxt;
            r_ones  <= w_ones_nxt;
            r_base  <= w_base_nxt;
            r_chal  <= w_chal_nxt;
            r_ro_en <= w_ro_en_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_sync  <= {r_sync[0], response};
        end
    end

    assign busy       = r_busy;
    assign ro_en      = r_ro_en;
    assign challenge  = r_chal;
    assign resp_valid = r_valid;
    assign resp_data  = r_data;

endmodule
